// File: rtl/mem_ctrl_if.sv
// Request/response bus between a CPU-side requester and mem_ctrl.
// The master issues data/xdata reads and writes; the slave returns read data and busy.
interface mem_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 16
);
    logic [AW-1:0] rd_addr;
    logic          data_rd_en;
    logic          xdata_rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          data_wr_en;
    logic          xdata_wr_en;
    logic          busy;

    modport master (
        output rd_addr, data_rd_en, xdata_rd_en,
        output wr_addr, wr_data, data_wr_en, xdata_wr_en,
        input  rd_data, rd_vld, busy
    );

    modport slave (
        input  rd_addr, data_rd_en, xdata_rd_en,
        input  wr_addr, wr_data, data_wr_en, xdata_wr_en,
        output rd_data, rd_vld, busy
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: single-cycle internal RAM and port registers in data space,
// plus a wait-stated external xdata memory sequenced by a small FSM.
module mem_ctrl #(
    parameter int DW         = 8,
    parameter int AW         = 16,
    parameter int IRAM_DEPTH = 128,
    parameter int XWAIT      = 2,
    parameter int NPORT      = 4,
    parameter int PORT_BASE  = 8'h80
) (
    input  logic                clk,
    input  logic                rst,
    mem_ctrl_if.slave           bus,
    output logic [AW-1:0]       xmem_addr,
    output logic [DW-1:0]       xmem_wdata,
    input  logic [DW-1:0]       xmem_rdata,
    output logic                xmem_re,
    output logic                xmem_we,
    input  logic [NPORT*DW-1:0] port_in,
    output logic [NPORT*DW-1:0] port_out,
    output logic [NPORT*DW-1:0] port_oe
);
    localparam int IW = (IRAM_DEPTH > 1) ? $clog2(IRAM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, XRD, XWR, DONE} state_t;

    state_t        state_reg;
    logic          busy_reg;
    logic          rd_vld_reg;
    logic [DW-1:0] rd_data_reg;
    logic          xmem_re_reg;
    logic          xmem_we_reg;
    logic [AW-1:0] xmem_addr_reg;
    logic [DW-1:0] xmem_wdata_reg;
    logic [3:0]    wait_cnt_reg;

    logic [DW-1:0] ram [IRAM_DEPTH];

    logic             idle;
    logic             accept_data_rd;
    logic             accept_data_wr;
    logic             accept_xrd;
    logic             accept_xwr;
    logic             rd_iram;
    logic             wr_iram;
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    wr_idx;
    logic [NPORT-1:0] rd_port_hit;
    logic [NPORT-1:0] wr_port_hit;
    logic [DW-1:0]    port_rd_val;

    assign idle = (state_reg == IDLE);

    // Data-space access has priority over an xdata read; an xdata write loses to any xdata read.
    assign accept_data_rd = idle && bus.data_rd_en;
    assign accept_data_wr = idle && bus.data_wr_en;
    assign accept_xrd     = idle && bus.xdata_rd_en && !bus.data_rd_en;
    assign accept_xwr     = idle && bus.xdata_wr_en && !bus.xdata_rd_en;

    assign rd_iram = (bus.rd_addr < AW'(IRAM_DEPTH));
    assign wr_iram = (bus.wr_addr < AW'(IRAM_DEPTH));
    assign rd_idx  = bus.rd_addr[IW-1:0];
    assign wr_idx  = bus.wr_addr[IW-1:0];

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            localparam logic [AW-1:0] PADDR = AW'(PORT_BASE + 16 * gi);
            logic [DW-1:0] latch_reg;

            assign rd_port_hit[gi] = (bus.rd_addr == PADDR) && !rd_iram;
            assign wr_port_hit[gi] = (bus.wr_addr == PADDR) && !wr_iram;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    latch_reg <= '1;
                end else if (accept_data_wr && wr_port_hit[gi]) begin
                    latch_reg <= bus.wr_data;
                end
            end

            // Quasi-bidirectional: a 1 in the latch releases the pin, a 0 drives it low.
            assign port_out[gi*DW +: DW] = latch_reg;
            assign port_oe[gi*DW +: DW]  = ~latch_reg;
        end
    endgenerate

    // Port reads return the pin value; unmapped addresses fall through to zero.
    always_comb begin
        port_rd_val = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (rd_port_hit[k]) begin
                port_rd_val = port_in[k*DW +: DW];
            end
        end
    end

    // RAM deliberately has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (rst && accept_data_wr && wr_iram) begin
            ram[wr_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            rd_vld_reg     <= 1'b0;
            rd_data_reg    <= '0;
            xmem_re_reg    <= 1'b0;
            xmem_we_reg    <= 1'b0;
            xmem_addr_reg  <= '0;
            xmem_wdata_reg <= '0;
            wait_cnt_reg   <= '0;
        end else begin
            rd_vld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept_data_rd) begin
                        rd_vld_reg <= 1'b1;
                        if (rd_iram) begin
                            rd_data_reg <= ram[rd_idx];
                        end else begin
                            rd_data_reg <= port_rd_val;
                        end
                    end
                    if (accept_xrd) begin
                        state_reg     <= XRD;
                        busy_reg      <= 1'b1;
                        xmem_re_reg   <= 1'b1;
                        xmem_addr_reg <= bus.rd_addr;
                        wait_cnt_reg  <= 4'(XWAIT);
                    end else if (accept_xwr) begin
                        state_reg      <= XWR;
                        busy_reg       <= 1'b1;
                        xmem_we_reg    <= 1'b1;
                        xmem_addr_reg  <= bus.wr_addr;
                        xmem_wdata_reg <= bus.wr_data;
                        wait_cnt_reg   <= 4'(XWAIT);
                    end
                end
                XRD: begin
                    if (wait_cnt_reg == 4'd0) begin
                        rd_data_reg <= xmem_rdata;
                        rd_vld_reg  <= 1'b1;
                        xmem_re_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                XWR: begin
                    if (wait_cnt_reg == 4'd0) begin
                        xmem_we_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_vld   = rd_vld_reg;
    assign bus.busy     = busy_reg;
    assign xmem_re      = xmem_re_reg;
    assign xmem_we      = xmem_we_reg;
    assign xmem_addr    = xmem_addr_reg;
    assign xmem_wdata   = xmem_wdata_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: read data is scoreboarded through a queue,
// handshake/pin behaviour is checked inline by one task per scenario.
module tb_mem_ctrl;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NPORT = 4;
    localparam int XWAIT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    logic [AW-1:0]       xmem_addr;
    logic [DW-1:0]       xmem_wdata;
    logic [DW-1:0]       xmem_rdata;
    logic                xmem_re;
    logic                xmem_we;
    logic [NPORT*DW-1:0] port_in;
    logic [NPORT*DW-1:0] port_out;
    logic [NPORT*DW-1:0] port_oe;

    mem_ctrl #(
        .DW(DW), .AW(AW), .IRAM_DEPTH(128), .XWAIT(XWAIT), .NPORT(NPORT), .PORT_BASE(8'h80)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .xmem_addr(xmem_addr), .xmem_wdata(xmem_wdata), .xmem_rdata(xmem_rdata),
        .xmem_re(xmem_re), .xmem_we(xmem_we),
        .port_in(port_in), .port_out(port_out), .port_oe(port_oe)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] iram_m [128];

    // Scoreboard: every rd_vld strobe must match the oldest expected read.
    always @(negedge clk) begin
        if (bus.rd_vld === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_vld_unexpected: got strobe with data=%h, required no strobe", bus.rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h, required %h", bus.rd_data, e);
                end else begin
                    $display("read delivered data=%h", bus.rd_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.data_rd_en  = 1'b0;
        bus.xdata_rd_en = 1'b0;
        bus.data_wr_en  = 1'b0;
        bus.xdata_wr_en = 1'b0;
    endtask

    task automatic data_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.data_wr_en = 1'b1;
        step();
        bus.data_wr_en = 1'b0;
        if (a < 128) iram_m[a[6:0]] = d;
    endtask

    task automatic test_drain(input string name);
        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d reads outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_req();
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        port_in = '0;
        xmem_rdata = '0;
        step();
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rd_vld !== 1'b0 || bus.rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus: got busy=%b rd_vld=%b rd_data=%h, required 0 0 00", bus.busy, bus.rd_vld, bus.rd_data);
        end
        n_checks++;
        if (xmem_re !== 1'b0 || xmem_we !== 1'b0 || xmem_addr !== 16'h0 || xmem_wdata !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_xmem: got re=%b we=%b addr=%h wdata=%h, required 0 0 0000 00", xmem_re, xmem_we, xmem_addr, xmem_wdata);
        end
        n_checks++;
        if (port_out !== 32'hFFFF_FFFF || port_oe !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ports: got out=%h oe=%h, required ffffffff 00000000", port_out, port_oe);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_data_rw();
        logic [AW-1:0] addrs [4];
        addrs = '{16'h0000, 16'h0001, 16'h0040, 16'h007F};
        data_write(16'h0010, 8'h5A);
        bus.rd_addr = 16'h0010;
        bus.data_rd_en = 1'b1;
        exp_q.push_back(iram_m[16]);
        step();
        bus.data_rd_en = 1'b0;
        n_checks++;
        if (bus.rd_vld !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL data_rd_latency: got rd_vld=%b busy=%b, required 1 0", bus.rd_vld, bus.busy);
        end
        for (int i = 0; i < 4; i++) data_write(addrs[i], addrs[i][7:0] ^ 8'hC3);
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = addrs[i];
            bus.data_rd_en = 1'b1;
            exp_q.push_back(iram_m[addrs[i][6:0]]);
            step();
        end
        clear_req();
        step();
        // Same-cycle read and write of one address must see the old contents.
        bus.rd_addr = 16'h0010;
        bus.data_rd_en = 1'b1;
        exp_q.push_back(iram_m[16]);
        data_write(16'h0010, 8'h77);
        exp_q.push_back(iram_m[16]);
        bus.data_rd_en = 1'b1;
        step();
        clear_req();
        step();
        step();
        n_checks++;
        if (bus.rd_vld !== 1'b0 || bus.rd_data !== 8'h77) begin
            n_fail++;
            $display("FAIL rd_data_hold: got rd_vld=%b rd_data=%h, required 0 77", bus.rd_vld, bus.rd_data);
        end
        test_drain("data_rw");
    endtask

    task automatic test_ports();
        data_write(16'h0090, 8'h0F);
        n_checks++;
        if (port_out[15:8] !== 8'h0F || port_oe[15:8] !== 8'hF0 || port_out[7:0] !== 8'hFF) begin
            n_fail++;
            $display("FAIL port1_write: got out=%h oe=%h, required out[15:8]=0f oe[15:8]=f0 out[7:0]=ff", port_out, port_oe);
        end
        port_in = 32'h11_22_3C_44;
        begin
            logic [AW-1:0] ra [6];
            logic [DW-1:0] rv [6];
            ra = '{16'h0090, 16'h0080, 16'h00B0, 16'h0085, 16'h00C0, 16'h0091};
            rv = '{8'h3C, 8'h44, 8'h11, 8'h00, 8'h00, 8'h00};
            for (int i = 0; i < 6; i++) begin
                bus.rd_addr = ra[i];
                bus.data_rd_en = 1'b1;
                exp_q.push_back(rv[i]);
                step();
            end
        end
        clear_req();
        data_write(16'h0085, 8'h00);
        data_write(16'h00B0, 8'hA0);
        n_checks++;
        if (port_out !== 32'hA0FF_0FFF || port_oe !== 32'h5F00_F000) begin
            n_fail++;
            $display("FAIL port_latches: got out=%h oe=%h, required a0ff0fff 5f00f000", port_out, port_oe);
        end
        test_drain("ports");
    endtask

    task automatic test_xdata_read();
        xmem_rdata = 8'h5E;
        bus.rd_addr = 16'h1234;
        bus.xdata_rd_en = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        clear_req();
        bus.rd_addr = 16'hFFFF;
        for (int c = 1; c <= XWAIT + 1; c++) begin
            n_checks++;
            if (xmem_re !== 1'b1 || xmem_addr !== 16'h1234 || bus.busy !== 1'b1 || bus.rd_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL xrd_cycle%0d: got re=%b addr=%h busy=%b vld=%b, required 1 1234 1 0", c, xmem_re, xmem_addr, bus.busy, bus.rd_vld);
            end
            // Only the last wait cycle carries the real data.
            xmem_rdata = (c == XWAIT + 1) ? 8'hA5 : 8'h5E - 8'(c);
            step();
        end
        n_checks++;
        if (bus.rd_vld !== 1'b1 || xmem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL xrd_done: got vld=%b re=%b, required 1 0", bus.rd_vld, xmem_re);
        end
        xmem_rdata = 8'h00;
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rd_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL xrd_idle: got busy=%b vld=%b, required 0 0", bus.busy, bus.rd_vld);
        end
        test_drain("xdata_read");
    endtask

    task automatic test_xdata_write();
        bus.wr_addr = 16'h2000;
        bus.wr_data = 8'h3E;
        bus.xdata_wr_en = 1'b1;
        step();
        clear_req();
        bus.wr_addr = 16'h0000;
        bus.wr_data = 8'hFF;
        for (int c = 1; c <= XWAIT + 1; c++) begin
            n_checks++;
            if (xmem_we !== 1'b1 || xmem_re !== 1'b0 || xmem_addr !== 16'h2000 || xmem_wdata !== 8'h3E || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL xwr_cycle%0d: got we=%b re=%b addr=%h wdata=%h busy=%b, required 1 0 2000 3e 1", c, xmem_we, xmem_re, xmem_addr, xmem_wdata, bus.busy);
            end
            step();
        end
        n_checks++;
        if (xmem_we !== 1'b0 || bus.busy !== 1'b0 || bus.rd_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL xwr_end: got we=%b busy=%b vld=%b, required 0 0 0", xmem_we, bus.busy, bus.rd_vld);
        end
        test_drain("xdata_write");
    endtask

    task automatic test_busy_ignore();
        xmem_rdata = 8'h6C;
        bus.rd_addr = 16'h0300;
        bus.wr_addr = 16'h0400;
        bus.wr_data = 8'h12;
        bus.xdata_rd_en = 1'b1;
        bus.xdata_wr_en = 1'b1;
        exp_q.push_back(8'h6C);
        step();
        for (int c = 1; c <= XWAIT + 1; c++) begin
            n_checks++;
            if (xmem_we !== 1'b0 || xmem_re !== 1'b1 || xmem_addr !== 16'h0300) begin
                n_fail++;
                $display("FAIL busy_cycle%0d: got we=%b re=%b addr=%h, required 0 1 0300", c, xmem_we, xmem_re, xmem_addr);
            end
            bus.rd_addr = 16'h0010;
            bus.wr_addr = 16'h0010;
            bus.wr_data = 8'h99;
            bus.data_rd_en = 1'b1;
            bus.data_wr_en = 1'b1;
            bus.xdata_rd_en = 1'b1;
            bus.xdata_wr_en = 1'b1;
            step();
        end
        clear_req();
        n_checks++;
        if (xmem_we !== 1'b0 || bus.rd_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: got we=%b vld=%b, required 0 1", xmem_we, bus.rd_vld);
        end
        step();
        n_checks++;
        if (xmem_we !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after: got we=%b busy=%b, required 0 0", xmem_we, bus.busy);
        end
        bus.rd_addr = 16'h0010;
        bus.data_rd_en = 1'b1;
        exp_q.push_back(iram_m[16]);
        step();
        clear_req();
        test_drain("busy_ignore");
    endtask

    task automatic test_mixed();
        bus.rd_addr = 16'h0010;
        bus.data_rd_en = 1'b1;
        bus.xdata_rd_en = 1'b1;
        exp_q.push_back(iram_m[16]);
        step();
        clear_req();
        n_checks++;
        if (bus.rd_vld !== 1'b1 || xmem_re !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_rd: got vld=%b re=%b busy=%b, required 1 0 0", bus.rd_vld, xmem_re, bus.busy);
        end
        step();
        n_checks++;
        if (bus.rd_vld !== 1'b0 || xmem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_rd_after: got vld=%b re=%b, required 0 0", bus.rd_vld, xmem_re);
        end
        // Data write alongside an xdata read: both must be taken.
        xmem_rdata = 8'hD4;
        bus.rd_addr = 16'h0042;
        bus.xdata_rd_en = 1'b1;
        exp_q.push_back(8'hD4);
        data_write(16'h0020, 8'h66);
        clear_req();
        n_checks++;
        if (xmem_re !== 1'b1 || xmem_addr !== 16'h0042) begin
            n_fail++;
            $display("FAIL mixed_wr_xrd: got re=%b addr=%h, required 1 0042", xmem_re, xmem_addr);
        end
        for (int c = 0; c < XWAIT + 2; c++) step();
        bus.rd_addr = 16'h0020;
        bus.data_rd_en = 1'b1;
        exp_q.push_back(iram_m[32]);
        step();
        clear_req();
        test_drain("mixed");
    endtask

    task automatic test_mid_reset();
        data_write(16'h00A0, 8'h00);
        bus.rd_addr = 16'h5555;
        bus.xdata_rd_en = 1'b1;
        step();
        clear_req();
        n_checks++;
        if (xmem_re !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_start: got re=%b busy=%b, required 1 1", xmem_re, bus.busy);
        end
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || xmem_re !== 1'b0 || bus.rd_vld !== 1'b0 || port_out !== 32'hFFFF_FFFF || port_oe !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst: got busy=%b re=%b vld=%b out=%h oe=%h, required 0 0 0 ffffffff 00000000", bus.busy, xmem_re, bus.rd_vld, port_out, port_oe);
        end
        rst = 1'b1;
        for (int c = 0; c < XWAIT + 3; c++) begin
            step();
            n_checks++;
            if (bus.rd_vld !== 1'b0 || xmem_re !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet%0d: got vld=%b re=%b, required 0 0", c, bus.rd_vld, xmem_re);
            end
        end
        bus.rd_addr = 16'h0010;
        bus.data_rd_en = 1'b1;
        exp_q.push_back(iram_m[16]);
        step();
        bus.rd_addr = 16'h007F;
        exp_q.push_back(iram_m[127]);
        step();
        clear_req();
        test_drain("mid_reset");
    endtask

    initial begin
        test_reset();
        test_data_rw();
        test_ports();
        test_xdata_read();
        test_xdata_write();
        test_busy_ignore();
        test_mixed();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
